// File: rtl/eth_pcs_66_64_dec.sv
// 10GBASE-R receive 64b/66b decoder: gathers a 66-bit block over narrow transfers,
// classifies and decodes it through the receive state machine and replays it as XGMII.

package eth_pcs_params_pkg;
    localparam int unsigned W_BYTE          = 8;
    localparam int unsigned N_CHANNELS      = 4;
    localparam int unsigned W_SYNC          = 2;
    localparam int unsigned W_DATA          = N_CHANNELS * W_BYTE;
    localparam int unsigned N_TRANS_PER_BLK = 2;
    localparam int unsigned W_TRANS_PER_BLK = 1;
    localparam int unsigned W_BLK           = W_DATA * N_TRANS_PER_BLK;
    localparam int unsigned N_LANES         = W_BLK / W_BYTE;
    localparam int unsigned W_CODE          = 7;

    localparam logic [W_SYNC-1:0] SYNC_DATA = 2'b01;
    localparam logic [W_SYNC-1:0] SYNC_CTRL = 2'b10;

    localparam logic [7:0] C_TYPE  = 8'h1E;
    localparam logic [7:0] S0_TYPE = 8'h78;
    localparam logic [7:0] S4_TYPE = 8'h33;
    localparam logic [7:0] T0_TYPE = 8'h87;
    localparam logic [7:0] T1_TYPE = 8'h99;
    localparam logic [7:0] T2_TYPE = 8'hAA;
    localparam logic [7:0] T3_TYPE = 8'hB4;
    localparam logic [7:0] T4_TYPE = 8'hCC;
    localparam logic [7:0] T5_TYPE = 8'hD2;
    localparam logic [7:0] T6_TYPE = 8'hE1;
    localparam logic [7:0] T7_TYPE = 8'hFF;

    localparam logic [W_CODE-1:0] CODE_IDLE = 7'h00;

    localparam logic [7:0] SYM_IDLE  = 8'h07;
    localparam logic [7:0] SYM_START = 8'hFB;
    localparam logic [7:0] SYM_TERM  = 8'hFD;
    localparam logic [7:0] SYM_ERR   = 8'hFE;
endpackage

module eth_pcs_66_64_dec
    import eth_pcs_params_pkg::*;
(
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_clk_en,
    input  logic [W_TRANS_PER_BLK-1:0] i_trans_cnt,
    input  logic                       i_blk_lock,
    input  logic [W_SYNC-1:0]          i_sync_data,
    input  logic [W_DATA-1:0]          i_pld_data,
    output logic [N_CHANNELS-1:0]      o_xgmii_ctrl,
    output logic [W_DATA-1:0]          o_xgmii_data,
    output logic                       o_blk_err
);

    typedef enum logic [2:0] {RX_INIT, RX_C, RX_D, RX_T, RX_E} rx_state_t;
    typedef enum logic [2:0] {BLK_C, BLK_S, BLK_D, BLK_T, BLK_E} blk_cls_t;

    localparam int unsigned W_STORED = W_BLK - W_DATA;

    rx_state_t               r_state;
    rx_state_t               w_state_nxt;
    rx_state_t               w_fsm_nxt;
    blk_cls_t                w_cls;

    logic [W_SYNC-1:0]       r_sync;
    logic [W_STORED-1:0]     r_pld;
    logic                    r_have_first;
    logic [W_BLK-1:0]        r_out_data;
    logic [N_LANES-1:0]      r_out_ctrl;
    logic                    r_blk_err;

    logic [W_BLK-1:0]        w_blk;
    logic [W_BLK-1:0]        w_blk_sh;
    logic [7:0]              w_type;
    logic [2:0]              w_t_pos;
    logic [W_BLK-1:0]        w_dec_data;
    logic [N_LANES-1:0]      w_dec_ctrl;
    logic [W_BLK-1:0]        w_out_data_nxt;
    logic [N_LANES-1:0]      w_out_ctrl_nxt;
    logic                    w_blk_err_nxt;
    logic                    w_decode_pt;

    assign w_blk       = {i_pld_data, r_pld};
    assign w_blk_sh    = w_blk >> W_BYTE;
    assign w_type      = w_blk[7:0];
    // A block whose first transfer was lost to reset is never decoded.
    assign w_decode_pt = i_clk_en && r_have_first &&
                         (i_trans_cnt == W_TRANS_PER_BLK'(N_TRANS_PER_BLK - 1));

    // Block classification from sync header and type byte
    always_comb begin
        w_cls   = BLK_E;
        w_t_pos = 3'd0;
        if (r_sync == SYNC_DATA) begin
            w_cls = BLK_D;
        end else if (r_sync == SYNC_CTRL) begin
            case (w_type)
                C_TYPE:           w_cls = BLK_C;
                S0_TYPE, S4_TYPE: w_cls = BLK_S;
                T0_TYPE: begin w_cls = BLK_T; w_t_pos = 3'd0; end
                T1_TYPE: begin w_cls = BLK_T; w_t_pos = 3'd1; end
                T2_TYPE: begin w_cls = BLK_T; w_t_pos = 3'd2; end
                T3_TYPE: begin w_cls = BLK_T; w_t_pos = 3'd3; end
                T4_TYPE: begin w_cls = BLK_T; w_t_pos = 3'd4; end
                T5_TYPE: begin w_cls = BLK_T; w_t_pos = 3'd5; end
                T6_TYPE: begin w_cls = BLK_T; w_t_pos = 3'd6; end
                T7_TYPE: begin w_cls = BLK_T; w_t_pos = 3'd7; end
                default:          w_cls = BLK_E;
            endcase
        end
    end

    // Block decode to eight XGMII lanes
    always_comb begin
        w_dec_data = {N_LANES{SYM_ERR}};
        w_dec_ctrl = '1;
        case (w_cls)
            BLK_D: begin
                w_dec_data = w_blk;
                w_dec_ctrl = '0;
            end
            BLK_C: begin
                for (int j = 0; j < int'(N_LANES); j++) begin
                    w_dec_data[W_BYTE*j +: W_BYTE] =
                        (w_blk[W_BYTE + W_CODE*j +: W_CODE] == CODE_IDLE) ? SYM_IDLE : SYM_ERR;
                end
            end
            BLK_S: begin
                if (w_type == S0_TYPE) begin
                    w_dec_data = {w_blk[W_BLK-1:8], SYM_START};
                    w_dec_ctrl = 8'h01;
                end else begin
                    w_dec_data = {w_blk[W_BLK-1:40], SYM_START, {4{SYM_IDLE}}};
                    w_dec_ctrl = 8'h1F;
                end
            end
            BLK_T: begin
                for (int j = 0; j < int'(N_LANES); j++) begin
                    if (j < int'(w_t_pos)) begin
                        w_dec_data[W_BYTE*j +: W_BYTE] = w_blk_sh[W_BYTE*j +: W_BYTE];
                        w_dec_ctrl[j] = 1'b0;
                    end else if (j == int'(w_t_pos)) begin
                        w_dec_data[W_BYTE*j +: W_BYTE] = SYM_TERM;
                    end else begin
                        w_dec_data[W_BYTE*j +: W_BYTE] = SYM_IDLE;
                    end
                end
            end
            default: ;
        endcase
    end

    // Receive state machine: next state and registered output block
    always_comb begin
        w_fsm_nxt      = RX_E;
        w_state_nxt    = r_state;
        w_out_data_nxt = r_out_data;
        w_out_ctrl_nxt = r_out_ctrl;
        w_blk_err_nxt  = r_blk_err;

        case (r_state)
            RX_D: begin
                case (w_cls)
                    BLK_D:   w_fsm_nxt = RX_D;
                    BLK_T:   w_fsm_nxt = RX_T;
                    default: w_fsm_nxt = RX_E;
                endcase
            end
            RX_E: begin
                case (w_cls)
                    BLK_C:   w_fsm_nxt = RX_C;
                    BLK_S:   w_fsm_nxt = RX_D;
                    BLK_D:   w_fsm_nxt = RX_D;
                    BLK_T:   w_fsm_nxt = RX_T;
                    default: w_fsm_nxt = RX_E;
                endcase
            end
            default: begin
                case (w_cls)
                    BLK_C:   w_fsm_nxt = RX_C;
                    BLK_S:   w_fsm_nxt = RX_D;
                    default: w_fsm_nxt = RX_E;
                endcase
            end
        endcase

        if (w_decode_pt) begin
            if (!i_blk_lock) begin
                w_state_nxt    = RX_INIT;
                w_out_data_nxt = {N_LANES{SYM_ERR}};
                w_out_ctrl_nxt = '1;
                w_blk_err_nxt  = 1'b0;
            end else if (w_fsm_nxt == RX_E) begin
                w_state_nxt    = RX_E;
                w_out_data_nxt = {N_LANES{SYM_ERR}};
                w_out_ctrl_nxt = '1;
                w_blk_err_nxt  = 1'b1;
            end else begin
                w_state_nxt    = w_fsm_nxt;
                w_out_data_nxt = w_dec_data;
                w_out_ctrl_nxt = w_dec_ctrl;
                w_blk_err_nxt  = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= RX_INIT;
            r_sync       <= '0;
            r_pld        <= '0;
            r_have_first <= 1'b0;
            r_out_data   <= {N_LANES{SYM_IDLE}};
            r_out_ctrl   <= '1;
            r_blk_err    <= 1'b0;
        end else if (i_clk_en) begin
            r_state    <= w_state_nxt;
            r_out_data <= w_out_data_nxt;
            r_out_ctrl <= w_out_ctrl_nxt;
            r_blk_err  <= w_blk_err_nxt;
            if (i_trans_cnt == '0) begin
                r_sync       <= i_sync_data;
                r_have_first <= 1'b1;
            end else if (w_decode_pt) begin
                r_have_first <= 1'b0;
            end
            for (int k = 0; k < int'(N_TRANS_PER_BLK) - 1; k++) begin
                if (i_trans_cnt == W_TRANS_PER_BLK'(k)) begin
                    r_pld[W_DATA*k +: W_DATA] <= i_pld_data;
                end
            end
        end
    end

    // Replay lane group selected by the live transfer index
    always_comb begin
        o_xgmii_data = r_out_data[W_DATA-1:0];
        o_xgmii_ctrl = r_out_ctrl[N_CHANNELS-1:0];
        for (int k = 1; k < int'(N_TRANS_PER_BLK); k++) begin
            if (i_trans_cnt == W_TRANS_PER_BLK'(k)) begin
                o_xgmii_data = r_out_data[W_DATA*k +: W_DATA];
                o_xgmii_ctrl = r_out_ctrl[N_CHANNELS*k +: N_CHANNELS];
            end
        end
    end

    assign o_blk_err = r_blk_err;

endmodule

// File: tb/tb_eth_pcs_66_64_dec.sv
// Directed bench for eth_pcs_66_64_dec: block sequences with hand-computed XGMII replay.

module tb_eth_pcs_66_64_dec;

    localparam logic [1:0]  SD = 2'b01;
    localparam logic [1:0]  SC = 2'b10;
    localparam logic [63:0] IDLE_P = 64'h0000_0000_0000_001E;
    localparam logic [63:0] S0_P   = 64'hD555_5555_5555_5578;
    localparam logic [63:0] S4_P   = 64'h5555_5500_0000_0033;
    localparam logic [63:0] T5_P   = 64'h0000_A5A4_A3A2_A1D2;
    localparam logic [31:0] IDL4   = 32'h0707_0707;
    localparam logic [31:0] ERR4   = 32'hFEFE_FEFE;

    logic        clk;
    logic        rst;
    logic        clk_en;
    logic [0:0]  trans_cnt;
    logic        blk_lock;
    logic [1:0]  sync_data;
    logic [31:0] pld_data;
    logic [3:0]  xgmii_ctrl;
    logic [31:0] xgmii_data;
    logic        blk_err;

    int checks;
    int errors;

    logic [3:0]  oc0, oc1;
    logic [31:0] od0, od1;
    logic        oe0, oe1;

    eth_pcs_66_64_dec dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_clk_en     (clk_en),
        .i_trans_cnt  (trans_cnt),
        .i_blk_lock   (blk_lock),
        .i_sync_data  (sync_data),
        .i_pld_data   (pld_data),
        .o_xgmii_ctrl (xgmii_ctrl),
        .o_xgmii_data (xgmii_data),
        .o_blk_err    (blk_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transfer: drive at the falling edge, sample the replayed outputs 1 ns later.
    task automatic xfer(input logic [0:0] cnt, input logic [1:0] s, input logic [31:0] p,
                        input logic en, input logic lk,
                        output logic [3:0] c, output logic [31:0] d, output logic e);
        @(negedge clk);
        trans_cnt = cnt;
        sync_data = s;
        pld_data  = p;
        clk_en    = en;
        blk_lock  = lk;
        #1;
        c = xgmii_ctrl;
        d = xgmii_data;
        e = blk_err;
    endtask

    task automatic blk(input logic [1:0] s, input logic [63:0] p, input logic lk);
        xfer(1'b0, s, p[31:0],  1'b1, lk, oc0, od0, oe0);
        xfer(1'b1, s, p[63:32], 1'b1, lk, oc1, od1, oe1);
    endtask

    // Compare the replay of the previous block, seen during the block just sent.
    task automatic exp_blk(input string tag, input logic [3:0] c0, input logic [31:0] d0,
                           input logic [3:0] c1, input logic [31:0] d1, input logic e);
        chk({tag, "_ctrl0"}, 32'(oc0), 32'(c0));
        chk({tag, "_data0"}, od0, d0);
        chk({tag, "_ctrl1"}, 32'(oc1), 32'(c1));
        chk({tag, "_data1"}, od1, d1);
        chk({tag, "_err0"},  32'(oe0), 32'(e));
        chk({tag, "_err1"},  32'(oe1), 32'(e));
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        clk       = 1'b0;
        rst       = 1'b1;
        clk_en    = 1'b1;
        blk_lock  = 1'b1;
        trans_cnt = 1'b0;
        sync_data = 2'b00;
        pld_data  = '0;

        @(negedge clk);
        #1;
        chk("rst_ctrl0", 32'(xgmii_ctrl), 32'hF);
        chk("rst_data0", xgmii_data, IDL4);
        chk("rst_err",   32'(blk_err), 32'h0);
        trans_cnt = 1'b1;
        #1;
        chk("rst_ctrl1", 32'(xgmii_ctrl), 32'hF);
        chk("rst_data1", xgmii_data, IDL4);
        @(negedge clk);
        rst = 1'b0;

        blk(SC, IDLE_P, 1'b1);                     exp_blk("rst_idle", 4'hF, IDL4, 4'hF, IDL4, 1'b0);
        blk(SC, IDLE_P, 1'b1);                     exp_blk("c1", 4'hF, IDL4, 4'hF, IDL4, 1'b0);
        blk(SC, S0_P, 1'b1);                       exp_blk("c2", 4'hF, IDL4, 4'hF, IDL4, 1'b0);
        blk(SD, 64'h0807_0605_0403_0201, 1'b1);    exp_blk("s0", 4'h1, 32'h5555_55FB, 4'h0, 32'hD555_5555, 1'b0);
        blk(SD, 64'h1122_3344_5566_7788, 1'b1);    exp_blk("d1", 4'h0, 32'h0403_0201, 4'h0, 32'h0807_0605, 1'b0);
        blk(SD, 64'hDEAD_BEEF_CAFE_F00D, 1'b1);    exp_blk("d2", 4'h0, 32'h5566_7788, 4'h0, 32'h1122_3344, 1'b0);
        blk(SD, 64'h0123_4567_89AB_CDEF, 1'b1);    exp_blk("d3", 4'h0, 32'hCAFE_F00D, 4'h0, 32'hDEAD_BEEF, 1'b0);
        blk(SC, T5_P, 1'b1);                       exp_blk("d4", 4'h0, 32'h89AB_CDEF, 4'h0, 32'h0123_4567, 1'b0);
        blk(SC, IDLE_P, 1'b1);                     exp_blk("t5", 4'h0, 32'hA4A3_A2A1, 4'hE, 32'h0707_FDA5, 1'b0);
        blk(SD, 64'h1111_1111_1111_1111, 1'b1);    exp_blk("c_after_t", 4'hF, IDL4, 4'hF, IDL4, 1'b0);
        blk(SC, IDLE_P, 1'b1);                     exp_blk("d_after_c", 4'hF, ERR4, 4'hF, ERR4, 1'b1);
        blk(2'b11, IDLE_P, 1'b1);                  exp_blk("recover1", 4'hF, IDL4, 4'hF, IDL4, 1'b0);
        blk(SC, IDLE_P, 1'b1);                     exp_blk("sync11", 4'hF, ERR4, 4'hF, ERR4, 1'b1);
        blk(SC, 64'h0, 1'b1);                      exp_blk("recover2", 4'hF, IDL4, 4'hF, IDL4, 1'b0);
        blk(SC, IDLE_P, 1'b1);                     exp_blk("type00", 4'hF, ERR4, 4'hF, ERR4, 1'b1);
        blk(SC, S4_P, 1'b1);                       exp_blk("recover3", 4'hF, IDL4, 4'hF, IDL4, 1'b0);
        blk(SD, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1);    exp_blk("s4", 4'hF, IDL4, 4'h1, 32'h5555_55FB, 1'b0);
        blk(SD, 64'hBBBB_BBBB_BBBB_BBBB, 1'b0);    exp_blk("d_after_s4", 4'h0, 32'hAAAA_AAAA, 4'h0, 32'hAAAA_AAAA, 1'b0);
        blk(SD, 64'hCCCC_CCCC_CCCC_CCCC, 1'b1);    exp_blk("lock_lost", 4'hF, ERR4, 4'hF, ERR4, 1'b0);
        blk(SC, S0_P, 1'b1);                       exp_blk("d_from_init", 4'hF, ERR4, 4'hF, ERR4, 1'b1);

        // Reset in the middle of a block
        xfer(1'b0, SD, 32'h0403_0201, 1'b1, 1'b1, oc0, od0, oe0);
        chk("pre_rst_ctrl0", 32'(oc0), 32'h1);
        chk("pre_rst_data0", od0, 32'h5555_55FB);
        @(negedge clk);
        trans_cnt = 1'b1;
        pld_data  = 32'h0807_0605;
        rst       = 1'b1;
        #1;
        chk("mid_rst_ctrl1", 32'(xgmii_ctrl), 32'hF);
        chk("mid_rst_data1", xgmii_data, IDL4);
        chk("mid_rst_err",   32'(blk_err), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        blk(SC, S0_P, 1'b1);                       exp_blk("post_rst", 4'hF, IDL4, 4'hF, IDL4, 1'b0);
        blk(SD, 64'h0807_0605_0403_0201, 1'b1);    exp_blk("s0_post_rst", 4'h1, 32'h5555_55FB, 4'h0, 32'hD555_5555, 1'b0);

        // Clock-enable gating with junk inputs in the middle of a block
        xfer(1'b0, SD, 32'h5566_7788, 1'b1, 1'b1, oc0, od0, oe0);
        chk("gate_pre_data0", od0, 32'h0403_0201);
        xfer(1'b0, 2'b11, 32'hFFFF_FFFF, 1'b0, 1'b1, oc0, od0, oe0);
        chk("gate1_ctrl0", 32'(oc0), 32'h0);
        chk("gate1_data0", od0, 32'h0403_0201);
        xfer(1'b1, 2'b11, 32'hEEEE_EEEE, 1'b0, 1'b0, oc1, od1, oe1);
        chk("gate2_data1", od1, 32'h0807_0605);
        chk("gate2_err",   32'(oe1), 32'h0);
        xfer(1'b0, 2'b00, 32'h0, 1'b0, 1'b1, oc0, od0, oe0);
        chk("gate3_data0", od0, 32'h0403_0201);
        xfer(1'b1, SD, 32'h1122_3344, 1'b1, 1'b1, oc1, od1, oe1);
        chk("gate_last_data1", od1, 32'h0807_0605);
        blk(SC, IDLE_P, 1'b1);                     exp_blk("gated_d", 4'h0, 32'h5566_7788, 4'h0, 32'h1122_3344, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/eth_pcs_66_64_dec.md
Name: eth_pcs_66_64_dec

Overview:
Receive-side 64b/66b decoder in the 10GBASE-R PCS. It collects one 66-bit block (sync header plus 64-bit payload) over N_TRANS_PER_BLK narrow transfers and classifies and decodes the block into XGMII control and data. It runs a simplified Clause 49 receive state machine and replays the decoded block as N_TRANS_PER_BLK XGMII transfers. It sits between the descrambler/block-lock stage and the RX MAC interface.

Parameters:
No module parameters. All widths come from cmn_params/eth_pcs_params, with these values:
- W_SYNC, 2, sync header width
- W_DATA, 32, transfer width (N_CHANNELS*W_BYTE)
- N_TRANS_PER_BLK, 2, transfers per 64-bit block
- W_TRANS_PER_BLK, 1, width of the transfer index

Ports:
- i_clk  in  1  PCS clock
- i_reset  in  1  reset; one clock, reset is asynchronous and active-high
- i_clk_en  in  1  qualifies every state update
- i_trans_cnt  in  W_TRANS_PER_BLK  transfer index within the block, 0..N_TRANS_PER_BLK-1
- i_blk_lock  in  1  block lock from the lock FSM; low means the input is untrusted
- i_sync_data  in  W_SYNC  sync header, sampled at transfer 0
- i_pld_data  in  W_DATA  payload slice for transfer i_trans_cnt
- o_xgmii_ctrl  out  N_CHANNELS  per-lane control flag for the current transfer
- o_xgmii_data  out  N_CHANNELS x W_BYTE  per-lane byte for the current transfer
- o_blk_err  out  1  high for the full block period after a block decodes to E

Behaviour:
- All registers update only when i_clk_en=1.
- Capture
  - Sync header is registered at i_trans_cnt==0.
  - Payload slice k is stored at block bits [32k+31:32k].
  - Type byte is block[7:0]; byte n is block[8n+7:8n].
- Decode point
  - Decoding happens when i_trans_cnt==N_TRANS_PER_BLK-1, using the stored slices plus the live final slice.
  - The result (64 data bits + 8 ctrl bits) is registered.
  - Output during transfer k of the following block is decoded lane group k.
  - Latency is exactly one block period (N_TRANS_PER_BLK enabled cycles).
- Classification
  - D: sync SYNC_DATA. Output ctrl=0 and data=payload.
  - C: sync SYNC_CTRL, type C_TYPE. The eight 7-bit codes at bits [63:8] map CODE_IDLE->SYM_IDLE and any other code->SYM_ERR; all ctrl=1.
  - S: type S0_TYPE gives lane0=SYM_START (ctrl=1), lanes1-7=payload bytes 1-7 (ctrl=0).
  - S: type S4_TYPE gives lanes0-3=SYM_IDLE (ctrl=1), lane4=SYM_START (ctrl=1), lanes5-7=payload bytes 5-7 (ctrl=0).
  - T: type Tn_TYPE (n=0..7) gives lanes 0..n-1 = payload bytes 1..n (ctrl=0), lane n=SYM_TERM (ctrl=1), lanes n+1..7=SYM_IDLE (ctrl=1).
  - E: sync 00 or 11, or an unrecognised type byte. Output all lanes SYM_ERR, all ctrl=1.
- Receive FSM (states RX_INIT, RX_C, RX_D, RX_T, RX_E), evaluated once per block at the decode point:
  - RX_INIT, RX_C, RX_T: C->RX_C; S->RX_D; anything else->RX_E.
  - RX_D: D->RX_D; T->RX_T; anything else->RX_E.
  - RX_E: C->RX_C; S->RX_D; D->RX_D; T->RX_T; E->RX_E.
- Output substitution
  - On a transition into RX_E, the registered output is the error block, even if the block itself decoded legally (e.g. D after C).
  - In every other transition the registered output is the decoded block.
- No T-block lookahead: a T block is accepted without checking the block that follows it.
- Block lock
  - i_blk_lock=0 at the decode point forces the state to RX_INIT and the output block to all SYM_ERR, ctrl=1.
  - o_blk_err stays 0 while lock is low.
- o_blk_err is registered with the output block: high for that block's N_TRANS_PER_BLK transfers iff the FSM entered RX_E.
- Reset, asynchronous, also mid-block:
  - State goes to RX_INIT.
  - Stored slices and sync are cleared.
  - Output block becomes all SYM_IDLE, ctrl=1; o_xgmii_ctrl='1 and o_xgmii_data=SYM_IDLE on every lane.
  - o_blk_err=0.
  - A partially collected block is discarded; collection restarts at the next i_trans_cnt==0.
- i_clk_en=0 freezes all state and registered outputs.
- o_xgmii_* is selected by the live i_trans_cnt.

Test Plan:
- Reset then idle: C blocks (sync 10, payload 0x00000000_0000001E) with lock high -> next block outputs ctrl=4'hF, data=4x07 on both transfers; state RX_C; o_blk_err=0.
- Frame sequence: S0 (type 0x78, bytes 1-7=0x55…0xD5), four D blocks, T5 (bytes 1-5=0xA1..0xA5) -> lane0=0xFB ctrl=1; D blocks pass through with ctrl=0; T5 output is lanes0-4 data, lane5=0xFD, lanes6-7=0x07 ctrl=1; o_blk_err stays 0.
- Illegal sequences: D directly after C; sync 2'b11; type 0x00 -> each block outputs all 0xFE ctrl=F for two transfers with o_blk_err=1. A following C block recovers to idle output with o_blk_err=0.
- S4 block (type 0x33, bytes 5-7=0x55) -> transfer 0: ctrl=F, data=4x07; transfer 1: ctrl=4'b0001, data={55,55,55,FB}; state RX_D.
- Lock and reset: drop i_blk_lock mid-frame -> error block output, state RX_INIT, no o_blk_err. Then assert i_reset during transfer 1 -> outputs immediately idle, and the first full block after release decodes correctly.
- Clock-enable gating: toggle i_clk_en=0 for 3 cycles mid-block -> outputs and state hold; decoded result matches the ungated run.
